// File: rtl/framebuf_bank_scheduler.sv
// framebuf_bank_scheduler: ping-pong bank controller for the camera frame buffer.
// Capture writes bank wr_bank while the painter reads rd_bank (= ~wr_bank).
// Banks swap only on a display vblank pulse, and only after a complete frame
// has been captured. A camera frame that would overwrite an unconsumed frame
// is dropped and counted.
//
// Ports:
//   clk50        system clock, all logic on posedge
//   rst          synchronous active-high reset
//   cap_sof      camera frame start pulse
//   cap_eof      camera last-pixel pulse (that pixel is still written)
//   cap_we       capture pixel write strobe
//   cap_addr     capture pixel address within a bank
//   disp_vblank  display vertical-blank entry pulse
//   disp_addr    painter read address within a bank
//   mem_we       gated write enable to the buffer RAM (zero latency)
//   mem_waddr    {wr_bank, cap_addr} (zero latency)
//   mem_raddr    {rd_bank, disp_addr} (zero latency)
//   wr_bank      bank owned by capture
//   rd_bank      bank owned by display
//   frame_valid  display bank holds a complete frame (sticky until rst)
//   swap_pulse   one-cycle pulse in the cycle after a swap
//   dropped      saturating count of discarded camera frames
module framebuf_bank_scheduler #(
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned DROP_W = 8
) (
    input  logic              clk50,
    input  logic              rst,
    input  logic              cap_sof,
    input  logic              cap_eof,
    input  logic              cap_we,
    input  logic [ADDR_W-1:0] cap_addr,
    input  logic              disp_vblank,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              mem_we,
    output logic [ADDR_W:0]   mem_waddr,
    output logic [ADDR_W:0]   mem_raddr,
    output logic              wr_bank,
    output logic              rd_bank,
    output logic              frame_valid,
    output logic              swap_pulse,
    output logic [DROP_W-1:0] dropped
);

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        WRITE    = 2'd1,
        PENDING  = 2'd2
    } state_t;

    localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

    state_t state;
    state_t state_nxt;
    logic   wr_bank_nxt;
    logic   frame_valid_nxt;
    logic   swap_pulse_nxt;
    logic   drop_inc;

    // Next-state and registered-output decode.
    always_comb begin
        state_nxt       = state;
        wr_bank_nxt     = wr_bank;
        frame_valid_nxt = frame_valid;
        swap_pulse_nxt  = 1'b0;
        drop_inc        = 1'b0;
        unique case (state)
            WAIT_SOF: begin
                if (cap_sof) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                // eof wins over a coincident sof; that new frame has nowhere to go
                if (cap_eof) begin
                    state_nxt = PENDING;
                    drop_inc  = cap_sof;
                end
            end
            PENDING: begin
                if (disp_vblank) begin
                    wr_bank_nxt     = ~wr_bank;
                    frame_valid_nxt = 1'b1;
                    swap_pulse_nxt  = 1'b1;
                    state_nxt       = cap_sof ? WRITE : WAIT_SOF;
                end else if (cap_sof) begin
                    drop_inc = 1'b1;
                end
            end
            default: begin
                state_nxt = WAIT_SOF;
            end
        endcase
    end

    // State and status registers.
    always_ff @(posedge clk50) begin
        if (rst) begin
            state       <= WAIT_SOF;
            wr_bank     <= 1'b0;
            frame_valid <= 1'b0;
            swap_pulse  <= 1'b0;
            dropped     <= '0;
        end else begin
            state       <= state_nxt;
            wr_bank     <= wr_bank_nxt;
            frame_valid <= frame_valid_nxt;
            swap_pulse  <= swap_pulse_nxt;
            if (drop_inc && (dropped != DROP_MAX)) begin
                dropped <= dropped + DROP_W'(1);
            end
        end
    end

    // Zero-latency memory-side paths keep pixel alignment unchanged.
    assign rd_bank   = ~wr_bank;
    assign mem_we    = cap_we && (state == WRITE) && !rst;
    assign mem_waddr = {wr_bank, cap_addr};
    assign mem_raddr = {rd_bank, disp_addr};

endmodule

// File: doc/framebuf_bank_scheduler.md
# framebuf_bank_scheduler

Ping-pong bank controller for the camera frame buffer. The buffer is split into two banks. The OV7670 capture path writes one bank while the VGA painter reads the other. The block sequences writes, swaps banks only during display vertical blank, drops camera frames that would overwrite an unconsumed frame, and gates display output until the first complete frame exists.

## Interface
Parameters:
- ADDR_W, 15, per-bank pixel address width (matches painter frame_addr).
- DROP_W, 8, width of the saturating dropped-frame counter.

Ports:
- clk50  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- cap_sof  in  1  one-cycle pulse: camera frame start (VSYNC edge).
- cap_eof  in  1  one-cycle pulse: last pixel of camera frame written this cycle.
- cap_we  in  1  capture pixel write strobe.
- cap_addr  in  ADDR_W  capture pixel address within a bank.
- disp_vblank  in  1  one-cycle pulse: display entered vertical blank (vCounter reached vRez).
- disp_addr  in  ADDR_W  painter read address within a bank.
- mem_we  out  1  gated write enable to buffer RAM.
- mem_waddr  out  ADDR_W+1  {wr_bank, cap_addr}.
- mem_raddr  out  ADDR_W+1  {rd_bank, disp_addr}.
- wr_bank  out  1  bank currently owned by capture.
- rd_bank  out  1  bank currently owned by display; always ~wr_bank.
- frame_valid  out  1  high once the display bank holds a complete frame.
- swap_pulse  out  1  one-cycle pulse, cycle after a swap is taken.
- dropped  out  DROP_W  count of camera frames discarded, saturating at all-ones.

## Operation
- FSM states: WAIT_SOF, WRITE, PENDING.
- WAIT_SOF: writes suppressed; cap_sof -> WRITE; cap_eof ignored.
- WRITE: mem_we = cap_we.
  - cap_eof -> PENDING.
  - cap_sof without eof restarts the frame in the same bank; stay in WRITE, no count.
  - cap_eof and cap_sof in the same cycle: eof wins -> PENDING, and the new frame counts as dropped (dropped+1).
- PENDING: wr_bank holds a complete frame; writes suppressed.
  - disp_vblank: toggle wr_bank/rd_bank, set frame_valid, swap_pulse next cycle.
    - If cap_sof is in the same cycle -> WRITE; that frame is captured into the new wr_bank, not counted.
    - Otherwise -> WAIT_SOF.
  - cap_sof without disp_vblank: dropped+1, stay in PENDING. Frames are not overwritten.
- disp_vblank outside PENDING: no effect.
- frame_valid is cleared only by rst. The painter blanks output while it is low.
- Once set, dropped stays at 2^DROP_W-1 until rst.
- rd_bank is never written. Invariant: rd_bank != wr_bank.

## Timing
- Reset values: state WAIT_SOF, wr_bank 0, rd_bank 1, frame_valid 0, swap_pulse 0, dropped 0, mem_we 0.
- rst mid-frame aborts the capture. A write strobe in the reset cycle is suppressed.
- mem_we, mem_waddr and mem_raddr are combinational from inputs and registered state, with zero latency. This keeps capture data and painter pixel alignment unchanged.
- State, bank and frame_valid update on the clock edge that samples the pulse. The next cycle's mem_waddr/mem_raddr use the new bank.
- In the cap_eof cycle the write is still enabled (last pixel lands); mem_we drops the following cycle.
- A swap never occurs outside a disp_vblank pulse. The display never sees a bank change mid-frame.
- Minimum frame-to-swap latency: cap_eof at cycle t, disp_vblank at t+1 -> banks toggle at edge t+1.

## Test plan
- Reset, then cap_we pulses with no cap_sof -> mem_we stays 0; wr_bank=0, rd_bank=1, frame_valid=0.
- cap_sof; 16 writes to addr 0..15; cap_eof; disp_vblank 10 cycles later -> mem_waddr 0x0000..0x000F with mem_we=1. Banks toggle at the vblank edge; swap_pulse is high for exactly 1 cycle; frame_valid=1; mem_raddr MSB=0 afterwards.
- From PENDING, issue 3 cap_sof pulses before any disp_vblank -> dropped=3, no mem_we asserted, wr_bank unchanged.
- PENDING with cap_sof and disp_vblank in the same cycle -> swap, state WRITE, writes go to the new bank on the next cycle, dropped unchanged.
- WRITE with cap_eof and cap_sof in the same cycle -> PENDING, dropped+1. Then force dropped to saturate with 300 extra drops -> dropped=255.
- Assert rst mid-WRITE with cap_we high -> mem_we=0 in that cycle; all outputs at reset values the next cycle.
